// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA scan engine.
package vga_pkg;

  // Cursor control word field positions
  localparam int CUR_COL_LSB   = 0;
  localparam int CUR_ROW_LSB   = 8;
  localparam int CUR_FREQ_LSB  = 16;
  localparam int CUR_EN_BIT    = 24;
  localparam int CUR_SHAPE_BIT = 25;

  // Default 640x480 timing
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic {
    PH_OFF = 1'b0,
    PH_ON  = 1'b1
  } blink_phase_e;

  // Ceiling log2, usable in constant expressions
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_cursor_blink.sv
// Cursor blink generator: prescaler ticks drive a period counter and phase FSM.
module vga_cursor_blink
  import vga_pkg::*;
#(
  parameter int BLINK_DIV = 390625,
  localparam int PW = clog2(BLINK_DIV)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] freq,
  output logic       phase
);

  logic [PW-1:0] presc;
  logic          tick;
  logic [7:0]    pcnt, pcnt_nxt;
  blink_phase_e  st, st_nxt;

  assign tick  = (presc == '0);
  assign phase = (st == PH_ON);

  // Prescaler: count down, tick at zero and reload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    presc <= PW'(BLINK_DIV - 1);
    else if (tick) presc <= PW'(BLINK_DIV - 1);
    else           presc <= presc - 1'b1;
  end

  // Phase and period counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= PH_OFF;
      pcnt <= '0;
    end else begin
      st   <= st_nxt;
      pcnt <= pcnt_nxt;
    end
  end

  // Per-tick update: freq 0 holds the cursor on, else toggle every freq+1 ticks
  always_comb begin
    st_nxt   = st;
    pcnt_nxt = pcnt;
    if (tick) begin
      if (freq == 8'd0) begin
        st_nxt = PH_ON;
      end else if (pcnt == 8'd0) begin
        st_nxt   = (st == PH_ON) ? PH_OFF : PH_ON;
        pcnt_nxt = freq;
      end else begin
        pcnt_nxt = pcnt - 8'd1;
      end
    end
  end

endmodule

// File: rtl/vga_text_scan.sv
// Raster counters, character-cell coordinates, delayed sync/blank and text cursor.
module vga_text_scan
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int HS_POL    = 0,
  parameter int VS_POL    = 0,
  parameter int CHAR_W    = 8,
  parameter int CHAR_H    = 16,
  parameter int PIPE      = 2,
  parameter int BLINK_DIV = 390625,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW       = clog2(H_TOTAL),
  localparam int VW       = clog2(V_TOTAL),
  localparam int CW       = clog2(H_ACTIVE / CHAR_W),
  localparam int RW       = clog2(V_ACTIVE / CHAR_H),
  localparam int GXW      = clog2(CHAR_W),
  localparam int GYW      = clog2(CHAR_H)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [31:0]    ctrl,
  output logic [HW-1:0]  hcoord,
  output logic [VW-1:0]  vcoord,
  output logic [CW-1:0]  col,
  output logic [RW-1:0]  row,
  output logic [GXW-1:0] glyph_x,
  output logic [GYW-1:0] glyph_y,
  output logic           frame_start,
  output logic           cursor_en,
  output logic           hsync,
  output logic           vsync,
  output logic           blank
);

  localparam logic       HS_ON     = 1'(HS_POL);
  localparam logic       VS_ON     = 1'(VS_POL);
  // Delay-line word is {hsync, vsync, blank}
  localparam logic [2:0] SYNC_IDLE = {~HS_ON, ~VS_ON, 1'b1};

  logic                  active, hs_win, vs_win;
  logic [PIPE-1:0][2:0]  sync_pipe;
  logic [CW-1:0]         sh_col;
  logic [RW-1:0]         sh_row;
  logic [7:0]            sh_freq;
  logic                  sh_en, sh_shape;
  logic                  cur_phase, shape_ok;

  assign col         = CW'(hcoord >> GXW);
  assign row         = RW'(vcoord >> GYW);
  assign glyph_x     = hcoord[GXW-1:0];
  assign glyph_y     = vcoord[GYW-1:0];
  assign frame_start = (hcoord == '0) && (vcoord == '0);
  assign active      = (hcoord < HW'(H_ACTIVE)) && (vcoord < VW'(V_ACTIVE));
  assign hs_win      = (hcoord >= HW'(H_ACTIVE + H_FP)) &&
                       (hcoord <  HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_win      = (vcoord >= VW'(V_ACTIVE + V_FP)) &&
                       (vcoord <  VW'(V_ACTIVE + V_FP + V_SYNC));
  assign {hsync, vsync, blank} = sync_pipe[PIPE-1];

  // Raster counters: h wraps each line, v advances on the h wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcoord <= '0;
      vcoord <= '0;
    end else if (hcoord == HW'(H_TOTAL - 1)) begin
      hcoord <= '0;
      vcoord <= (vcoord == VW'(V_TOTAL - 1)) ? '0 : vcoord + 1'b1;
    end else begin
      hcoord <= hcoord + 1'b1;
    end
  end

  // Sync/blank delay line so outputs line up with the downstream pixel pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_pipe <= {PIPE{SYNC_IDLE}};
    end else begin
      sync_pipe[0] <= {hs_win ? HS_ON : ~HS_ON, vs_win ? VS_ON : ~VS_ON, ~active};
      for (int i = 1; i < PIPE; i++) sync_pipe[i] <= sync_pipe[i-1];
    end
  end

  // Shadow of cursor control, captured only at frame start to avoid tearing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_col   <= '0;
      sh_row   <= '0;
      sh_freq  <= '0;
      sh_en    <= 1'b0;
      sh_shape <= 1'b0;
    end else if (frame_start) begin
      sh_col   <= ctrl[CUR_COL_LSB +: CW];
      sh_row   <= ctrl[CUR_ROW_LSB +: RW];
      sh_freq  <= ctrl[CUR_FREQ_LSB +: 8];
      sh_en    <= ctrl[CUR_EN_BIT];
      sh_shape <= ctrl[CUR_SHAPE_BIT];
    end
  end

  vga_cursor_blink #(
    .BLINK_DIV(BLINK_DIV)
  ) u_blink (
    .clk  (clk),
    .rst_n(rst_n),
    .freq (sh_freq),
    .phase(cur_phase)
  );

  // Underline shape only covers the bottom two glyph lines
  assign shape_ok = ~sh_shape | (glyph_y >= GYW'(CHAR_H - 2));

  // Cursor hit for the current pixel, presented one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cursor_en <= 1'b0;
    else        cursor_en <= sh_en & cur_phase & active & (col == sh_col) &
                             (row == sh_row) & shape_ok;
  end

endmodule

// File: doc/vga_text_scan.md
# vga_text_scan

Parametrised VGA scan engine for the SoC display subsystem: generates the raster counters, character-cell coordinates, sync/blank outputs and a hardware text cursor. It is the next-generation scan/cursor front end for the character/graphics VGA device. Unlike the fixed 640x480 design, it supports any timing, glyph size and sync polarity. It aligns sync/blank to a downstream video pipeline of configurable depth, and latches cursor control at frame start so the cursor cannot tear mid-frame.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- HS_POL / VS_POL, 0 / 0, sync assertion level (0 = active-low)
- CHAR_W / CHAR_H, 8 / 16, glyph cell size; each must be a power of 2
- PIPE, 2, delay in cycles (≥1) from counter state to hsync/vsync/blank
- BLINK_DIV, 390625, clock cycles per blink tick (≥2)

Derived widths: HW = clog2(H_TOTAL), VW = clog2(V_TOTAL), CW = clog2(H_ACTIVE/CHAR_W), RW = clog2(V_ACTIVE/CHAR_H).

Ports. One clock; reset is asynchronous and active-low.
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- ctrl  in  32  cursor control: [CW-1:0] column, [8+RW-1:8] row, [23:16] blink period, [24] enable, [25] shape (0 block, 1 underline)
- hcoord  out  HW  horizontal counter
- vcoord  out  VW  vertical counter
- col  out  CW  hcoord / CHAR_W
- row  out  RW  vcoord / CHAR_H
- glyph_x  out  clog2(CHAR_W)  hcoord % CHAR_W
- glyph_y  out  clog2(CHAR_H)  vcoord % CHAR_H
- frame_start  out  1  one-cycle pulse at hcoord = 0, vcoord = 0
- cursor_en  out  1  cursor covers the pixel at the previous cycle's coordinates
- hsync / vsync  out  1  sync outputs, delayed by PIPE
- blank  out  1  high outside the active area, delayed by PIPE

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined the same way.
- Horizontal counter: counts 0..H_TOTAL-1, then wraps to 0.
- Vertical counter: increments on the horizontal wrap and wraps from V_TOTAL-1 to 0.
- Active area: hcoord < H_ACTIVE and vcoord < V_ACTIVE.
- hsync is asserted (at level HS_POL) while H_ACTIVE+H_FP ≤ hcoord < H_ACTIVE+H_FP+H_SYNC. vsync uses the same rule on vcoord with VS_POL.
- col, row, glyph_x and glyph_y are combinational slices of the counters.
- Shadow control register: ctrl is copied into it only in the cycle where frame_start = 1. All cursor logic uses the shadow, never live ctrl.
- Blink prescaler: counts down from BLINK_DIV-1; reaching 0 produces a tick and reloads the prescaler.
- Blink FSM, evaluated on each tick:
  - period field = 0: phase is forced to 1 (steady cursor).
  - period ≠ 0 and period counter = 0: phase toggles and the period counter reloads with the period field.
  - otherwise the period counter decrements.
  - Net effect: the phase toggles every (period+1) ticks.
- cursor_en is registered from: enable & phase & active & (col = cursor column) & (row = cursor row) & (shape = 0 or glyph_y ≥ CHAR_H-2).
- A cursor column or row outside the visible range never matches, so cursor_en stays 0.

## Timing
- Reset values:
  - counters 0, so hcoord = vcoord = 0 and frame_start = 1 combinationally after release
  - hsync = ~HS_POL, vsync = ~VS_POL, blank = 1 for all PIPE stages
  - cursor_en 0, shadow 0 (cursor disabled), phase 0, period counter 0, prescaler BLINK_DIV-1
- Counter outputs have latency 0; frame_start is combinational from the counters.
- hsync/vsync/blank at cycle t reflect the counter state at cycle t-PIPE.
- cursor_en at cycle t reflects the counters and shadow at t-1.
- A ctrl change in the frame_start cycle takes effect immediately: cursor_en is evaluated against the new shadow at t+1. A change in any other cycle waits for the next frame start.
- When a tick and frame_start coincide, both take effect in the same cycle.
- Asserting reset mid-frame returns every register to its reset value asynchronously. The first line after reset release starts at hcoord = 0.

## Structure
- Shared package `vga_pkg`:
  - ctrl field position constants: CUR_COL_LSB, CUR_ROW_LSB, CUR_FREQ_LSB, CUR_EN_BIT, CUR_SHAPE_BIT
  - default 640x480 timing constants
  - clog2 function
- Sub-module `vga_cursor_blink`: blink prescaler, period counter and phase FSM.
- The remaining logic is the top-level raster counters plus the PIPE-stage sync/blank delay line.

## Test plan
- Default parameters after reset: hcoord wraps 799→0; vcoord wraps 524→0; frame_start pulses once every 420000 cycles.
- Sync and blank placement, PIPE = 2: hsync is low for hcoord 656..751 seen 2 cycles later; vsync is low for lines 490..491; blank = 0 exactly for the 640x480 area.
- ctrl = enable | row 3 | col 5 | freq 0 | block: cursor_en = 1 for hcoord 40..47, vcoord 48..63, each seen 1 cycle later. Underline shape limits this to vcoord 62..63.
- ctrl written mid-frame (col 5→9): the cursor stays at col 5 for the rest of the frame and moves to col 9 after the next frame_start.
- BLINK_DIV = 4, freq = 2: phase toggles every 12 cycles. freq = 0 with enable gives a steady cursor; enable = 0 gives cursor_en = 0 always.
- Non-default build: H_ACTIVE = 320, CHAR_W = 4, HS_POL = 1. Column 79 matches hcoord 316..319 and hsync is active-high. Asserting rst_n low mid-line clears all outputs to their reset values immediately.
